// File: rtl/tournament_pkg.sv
// Shared types for the tournament chooser scheduler: counter type, FSM states
// and the saturating chooser update rule.
package tournament_pkg;

    typedef logic [1:0] chooser_ctr_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } sched_state_t;

    // Move toward whichever predictor was uniquely correct; agreement leaves it alone.
    function automatic chooser_ctr_t chooser_next(input chooser_ctr_t ctr,
                                                  input logic         a,
                                                  input logic         b);
        chooser_ctr_t nxt;
        case ({a, b})
            2'b10:   nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
            2'b01:   nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tournament_upd_fifo.sv
// Small synchronous FIFO holding pending chooser updates as {idx, a, b}.
module tournament_upd_fifo #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = PW + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage and pointers; reset flushes all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy count; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tournament_chooser_sched.sv
// Shares the single chooser SRAM port between fetch lookups and queued
// read-modify-write updates, after an init sweep of the whole table.
module tournament_chooser_sched
    import tournament_pkg::*;
#(
    parameter int unsigned IDX_W    = 7,
    parameter int unsigned QDEPTH   = 4,
    parameter logic [1:0]  INIT_VAL = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_ready,
    output logic             lk_rvalid,
    output logic [1:0]       lk_rdata,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_a,
    input  logic             upd_b,
    output logic             upd_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             init_done
);

    localparam int unsigned      ENT_W    = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    sched_state_t     state_r;
    sched_state_t     next_state_s;
    logic [IDX_W-1:0] sweep_ptr_r;
    logic             init_done_r;
    logic             lk_rvalid_r;
    logic             q_full_s;
    logic             q_empty_s;
    logic [ENT_W-1:0] q_head_s;
    logic             push_s;
    logic             pop_s;
    logic             lk_fire_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             head_a_s;
    logic             head_b_s;

    assign head_idx_s = q_head_s[ENT_W-1:2];
    assign head_a_s   = q_head_s[1];
    assign head_b_s   = q_head_s[0];

    assign lk_ready  = init_done_r && (state_r == ST_IDLE) && !q_full_s;
    assign upd_ready = init_done_r && !q_full_s;
    assign lk_fire_s = lk_valid && lk_ready;
    // Agreeing outcomes cannot move the counter, so they never reach the queue.
    assign push_s    = upd_valid && upd_ready && (upd_a != upd_b);
    assign pop_s     = (state_r == ST_WR);
    assign init_done = init_done_r;
    assign lk_rvalid = lk_rvalid_r;

    tournament_upd_fifo #(
        .W     (ENT_W),
        .DEPTH (QDEPTH)
    ) u_upd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   ({upd_idx, upd_a, upd_b}),
        .pop   (pop_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .head  (q_head_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: a full queue preempts lookups so updates cannot starve forever.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_ptr_r == LAST_IDX) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (q_full_s) begin
                    next_state_s = ST_RD;
                end else if (lk_valid) begin
                    next_state_s = ST_IDLE;
                end else if (!q_empty_s) begin
                    next_state_s = ST_RD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD:   next_state_s = ST_WR;
            ST_WR:   next_state_s = ST_IDLE;
            default: next_state_s = ST_INIT;
        endcase
    end

    // Sweep pointer and init_done, which rises as the sweep leaves its last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_ptr_r <= '0;
            init_done_r <= 1'b0;
        end else if (state_r == ST_INIT) begin
            sweep_ptr_r <= sweep_ptr_r + IDX_W'(1);
            init_done_r <= (sweep_ptr_r == LAST_IDX);
        end else begin
            sweep_ptr_r <= sweep_ptr_r;
            init_done_r <= init_done_r;
        end
    end

    // One-cycle read-valid pulse following each accepted lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_rvalid_r <= 1'b0;
        end else begin
            lk_rvalid_r <= lk_fire_s;
        end
    end

    // Lookup data comes straight from the macro in the cycle after the read.
    always_comb begin
        if (lk_rvalid_r) begin
            lk_rdata = tbl_rdata;
        end else begin
            lk_rdata = 2'b00;
        end
    end

    // Table port drive; reset gates it off without waiting for a clock.
    always_comb begin
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = 2'b00;
        if (!rst_n) begin
            tbl_en = 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = sweep_ptr_r;
                    tbl_wdata = INIT_VAL;
                end
                ST_IDLE: begin
                    if (lk_fire_s) begin
                        tbl_en   = 1'b1;
                        tbl_addr = lk_idx;
                    end else begin
                        tbl_en = 1'b0;
                    end
                end
                ST_RD: begin
                    tbl_en   = 1'b1;
                    tbl_addr = head_idx_s;
                end
                ST_WR: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = head_idx_s;
                    tbl_wdata = chooser_next(tbl_rdata, head_a_s, head_b_s);
                end
                default: tbl_en = 1'b0;
            endcase
        end
    end

endmodule
